// File: rtl/apb_slave_regfile.sv
// APB completer with a small register file: register 0 is a read-only ID,
// programmable access-phase wait states, error response on bad accesses.
module apb_slave_regfile #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(32'hA9B0_0001)
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [ADDR_WIDTH-1:0]       paddr,
  input  logic [DATA_WIDTH-1:0]       pwdata,
  output logic                        pready,
  output logic [DATA_WIDTH-1:0]       prdata,
  output logic                        pslverr,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned RIDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    write_q;
  logic                    err_q;
  logic [RIDX_W-1:0]       idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  // Setup-phase decode straight from the bus; only ever consumed into flops
  logic [IDX_W-1:0]        setup_idx;
  logic [RIDX_W-1:0]       setup_ridx;
  logic                    setup_err;
  logic [DATA_WIDTH-1:0]   setup_rdata;

  always_comb begin
    setup_idx   = paddr[ADDR_WIDTH-1:2];
    setup_ridx  = RIDX_W'(setup_idx);
    setup_err   = (paddr[1:0] != 2'b00)
                || (32'(setup_idx) >= 32'(NUM_REGS))
                || (pwrite && (setup_idx == '0));
    setup_rdata = (setup_idx == '0) ? ID_VALUE : regs[setup_ridx];
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      pready   <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_pulse <= 1'b0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // penable without a preceding setup phase is ignored here
          if (psel && !penable) begin
            state   <= ST_ACCESS;
            cnt     <= CNT_W'(WAIT_STATES);
            write_q <= pwrite;
            idx_q   <= setup_ridx;
            wdata_q <= pwdata;
            err_q   <= setup_err;
            pready  <= (WAIT_STATES == 0);
            pslverr <= setup_err && (WAIT_STATES == 0);
            if (!pwrite) begin
              prdata <= setup_err ? '0 : setup_rdata;
            end
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (penable && pready) begin
            state <= ST_IDLE;
            if (write_q && !err_q) begin
              regs[idx_q] <= wdata_q;
              wr_pulse    <= 1'b1;
              wr_idx      <= idx_q;
            end
          end else if (cnt != '0) begin
            // pready tracks cnt==0 one flop ahead of the counter itself
            cnt     <= cnt - CNT_W'(1);
            pready  <= (cnt == CNT_W'(1));
            pslverr <= err_q && (cnt == CNT_W'(1));
          end else begin
            pready  <= 1'b1;
            pslverr <= err_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 2 and 3 wait states) on a
// shared bus, a transaction-level model, and a per-cycle compare process.
module tb_apb_slave_regfile;

  localparam int unsigned NINST = 3;
  localparam int unsigned NREG  = 16;
  localparam logic [31:0] ID    = 32'hA9B0_0001;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  logic              pclk = 1'b0;
  logic              preset = 1'b1;
  logic [NINST-1:0]  psel_v = '0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [7:0]        paddr = '0;
  logic [31:0]       pwdata = '0;

  logic [NINST-1:0]  pready_w;
  logic [NINST-1:0]  pslverr_w;
  logic [NINST-1:0]  wr_pulse_w;
  logic [31:0]       prdata_w [NINST];
  logic [3:0]        wr_idx_w [NINST];

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    apb_slave_regfile #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .NUM_REGS   (NREG),
      .WAIT_STATES(ws_of(g)),
      .ID_VALUE   (ID)
    ) u_dut (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel_v[g]),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pready  (pready_w[g]),
      .prdata  (prdata_w[g]),
      .pslverr (pslverr_w[g]),
      .wr_pulse(wr_pulse_w[g]),
      .wr_idx  (wr_idx_w[g])
    );
  end

  // Model state
  logic [31:0]      mem [NINST][NREG];
  logic [NINST-1:0] exp_pready = '0;
  logic [NINST-1:0] exp_pslverr = '0;
  logic [NINST-1:0] exp_wr_pulse = '0;
  logic [31:0]      exp_prdata [NINST];
  logic [3:0]       exp_wr_idx [NINST];
  bit               checking = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[inst %0d] @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (checking) begin
      for (int k = 0; k < NINST; k++) begin
        check("pready",   k, 32'(pready_w[k]),   32'(exp_pready[k]));
        check("pslverr",  k, 32'(pslverr_w[k]),  32'(exp_pslverr[k]));
        check("wr_pulse", k, 32'(wr_pulse_w[k]), 32'(exp_wr_pulse[k]));
        check("prdata",   k, prdata_w[k],        exp_prdata[k]);
        check("wr_idx",   k, 32'(wr_idx_w[k]),   32'(exp_wr_idx[k]));
      end
    end
  end

  // Advance one clock; transient expectations default to 0 for the new cycle
  task automatic cycle();
    @(posedge pclk);
    #1;
    exp_pready   = '0;
    exp_pslverr  = '0;
    exp_wr_pulse = '0;
  endtask

  task automatic reset_model();
    for (int k = 0; k < NINST; k++) begin
      for (int i = 0; i < NREG; i++) mem[k][i] = '0;
      exp_prdata[k] = '0;
      exp_wr_idx[k] = '0;
    end
  endtask

  task automatic do_reset(input int n);
    preset = 1'b1;
    repeat (n) begin
      cycle();
      reset_model();
    end
    preset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // mode 0: full transfer, 1: master abort after one access cycle,
  // 2: preset asserted after one access cycle
  task automatic xfer(input int k, input bit wr, input logic [7:0] addr,
                      input logic [31:0] data, input int mode,
                      output logic [31:0] rd, output logic err_seen, output int lat);
    int w, idx;
    bit err, last;
    logic [31:0] exp_rd;
    w   = ws_of(k);
    idx = int'(addr[7:2]);
    err = (addr[1:0] != 2'b00) || (idx >= NREG) || (wr && idx == 0);
    exp_rd = err ? 32'h0 : ((idx == 0) ? ID : mem[k][idx]);
    rd = '0;
    err_seen = 1'b0;
    lat = 0;
    psel_v    = '0;
    psel_v[k] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = data;
    cycle();
    penable = 1'b1;
    if (!wr) exp_prdata[k] = exp_rd;
    if (mode != 0) begin
      exp_pready[k]  = (w == 0);
      exp_pslverr[k] = err && (w == 0);
      if (mode == 1) begin
        psel_v  = '0;
        penable = 1'b0;
        cycle();
      end else begin
        preset = 1'b1;
        cycle();
        reset_model();
        preset  = 1'b0;
        psel_v  = '0;
        penable = 1'b0;
      end
      return;
    end
    for (int n = 1; n <= w + 1; n++) begin
      last = (n == w + 1);
      exp_pready[k]  = last;
      exp_pslverr[k] = err && last;
      if (pready_w[k] && lat == 0) lat = n;
      if (last) begin
        rd = prdata_w[k];
        err_seen = pslverr_w[k];
      end
      cycle();
    end
    psel_v  = '0;
    penable = 1'b0;
    if (wr && !err) begin
      mem[k][idx]     = data;
      exp_wr_pulse[k] = 1'b1;
      exp_wr_idx[k]   = 4'(idx);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        es;
    int          lat;
    logic [7:0]  addr;
    int          k;

    reset_model();
    do_reset(2);
    checking = 1'b1;

    // Reset values and initial reads
    check("rst_pready",  0, 32'(pready_w[0]),   32'd0);
    check("rst_prdata",  0, prdata_w[0],        32'd0);
    check("rst_wr_pulse",0, 32'(wr_pulse_w[0]), 32'd0);
    xfer(0, 1'b0, 8'h0C, 32'h0, 0, rd, es, lat);
    check("rd_reg3_after_rst", 0, rd, 32'h0);
    idle(1);
    xfer(0, 1'b0, 8'h00, 32'h0, 0, rd, es, lat);
    check("rd_id", 0, rd, 32'hA9B0_0001);
    idle(1);

    // Zero-wait write/read
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 0, rd, es, lat);
    check("wr_pulse_lit", 0, 32'(wr_pulse_w[0]), 32'd1);
    check("wr_idx_lit",   0, 32'(wr_idx_w[0]),   32'd1);
    check("wr_lat0",      0, 32'(lat),           32'd1);
    idle(1);
    check("wr_pulse_gone", 0, 32'(wr_pulse_w[0]), 32'd0);
    xfer(0, 1'b0, 8'h04, 32'h0, 0, rd, es, lat);
    check("rd_deadbeef", 0, rd, 32'hDEAD_BEEF);
    check("rd_err0",     0, 32'(es), 32'd0);
    idle(1);

    // Three wait states: pready on access cycle 4, 5 cycles total
    xfer(2, 1'b0, 8'h08, 32'h0, 0, rd, es, lat);
    check("ws3_lat", 2, 32'(lat), 32'd4);
    idle(1);

    // Error responses
    xfer(0, 1'b1, 8'h00, 32'h5555_AAAA, 0, rd, es, lat);
    check("wr_ro_err", 0, 32'(es), 32'd1);
    check("wr_ro_no_pulse", 0, 32'(wr_pulse_w[0]), 32'd0);
    xfer(0, 1'b0, 8'h00, 32'h0, 0, rd, es, lat);
    check("id_unchanged", 0, rd, 32'hA9B0_0001);
    xfer(0, 1'b0, 8'h41, 32'h0, 0, rd, es, lat);
    check("misalign_err",   0, 32'(es), 32'd1);
    check("misalign_rdata", 0, rd, 32'h0);
    xfer(0, 1'b0, 8'h40, 32'h0, 0, rd, es, lat);
    check("range_err", 0, 32'(es), 32'd1);
    idle(1);

    // penable without setup in IDLE is ignored
    psel_v[0] = 1'b1;
    penable   = 1'b1;
    cycle();
    psel_v  = '0;
    penable = 1'b0;
    cycle();
    check("idle_penable_ignored", 0, 32'(pready_w[0]), 32'd0);

    // Abort, then reset mid-access
    xfer(1, 1'b1, 8'h0C, 32'h0000_1234, 1, rd, es, lat);
    idle(1);
    xfer(1, 1'b0, 8'h0C, 32'h0, 0, rd, es, lat);
    check("abort_no_commit", 1, rd, 32'h0);
    idle(1);
    xfer(1, 1'b1, 8'h0C, 32'h0000_1234, 2, rd, es, lat);
    check("rst_mid_pready", 1, 32'(pready_w[1]), 32'd0);
    check("rst_mid_prdata", 1, prdata_w[1],      32'd0);
    idle(1);

    // Back-to-back write then read
    xfer(0, 1'b1, 8'h10, 32'h0000_0011, 0, rd, es, lat);
    check("b2b_wr_err", 0, 32'(es), 32'd0);
    xfer(0, 1'b0, 8'h10, 32'h0, 0, rd, es, lat);
    check("b2b_rd", 0, rd, 32'h0000_0011);
    check("b2b_rd_err", 0, 32'(es), 32'd0);
    idle(1);

    // Randomized traffic checked cycle by cycle against the model
    for (int t = 0; t < 200; t++) begin
      k = int'($urandom_range(0, NINST - 1));
      if ($urandom_range(0, 3) == 0) addr = 8'($urandom_range(0, 255));
      else addr = {2'b00, 4'($urandom_range(0, NREG - 1)), 2'b00};
      xfer(k, 1'($urandom_range(0, 1)), addr, $urandom,
           ($urandom_range(0, 19) == 0) ? 1 : 0, rd, es, lat);
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
